word_byte_sequencer: RTL and testbench
======================================

WORD_BYTE_SEQUENCER -- requirements
Module: word_byte_sequencer

Interface
REQ-001 Parameter MSB_FIRST, default 1, byte order: 1 = bits [31:24] first; 0 = bits [7:0] first.
REQ-002 Parameter CNT_W, default 16, width of the completed-word counter.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 in_valid  input  1  upstream word valid.
REQ-006 in_data  input  32  upstream word.
REQ-007 in_ready  output  1  block accepts a word this cycle.
REQ-008 flush  input  1  synchronous abort of the word in progress.
REQ-009 out_valid  output  1  byte on out_data is valid.
REQ-010 out_data  output  8  current byte of the held word.
REQ-011 out_idx  output  2  position of the current byte in emission order: 0 = first, 3 = last.
REQ-012 out_last  output  1  high when out_valid and out_idx == 3.
REQ-013 out_ready  input  1  downstream accepts the byte.
REQ-014 word_cnt  output  CNT_W  count of fully emitted words.

Function
REQ-015 States: IDLE (no word held) and SEND (word held in a 32-bit register, byte index 0..3).
REQ-016 An input transfer SHALL occur on a cycle with in_valid && in_ready; in_data SHALL be captured, the index SHALL be set to 0, and the state SHALL become SEND.
REQ-017 An output transfer SHALL occur on a cycle with out_valid && out_ready; the index SHALL advance by 1.
REQ-018 in_ready SHALL equal !flush && (IDLE || (out_valid && out_ready && out_last)), i.e. back-to-back words with zero bubble.
REQ-019 out_valid SHALL be 1 exactly in SEND and SHALL not depend combinationally on out_ready.
REQ-020 out_data: with MSB_FIRST=1, index k SHALL output held[31-8k : 24-8k]; with MSB_FIRST=0, it SHALL output held[8k+7 : 8k].
REQ-021 out_data, out_idx and out_last SHALL hold stable while out_valid && !out_ready (stall).
REQ-022 SEND, output transfer at index 3, no new input transfer -> IDLE.
REQ-023 SEND, output transfer at index 3, simultaneous input transfer -> remain in SEND with the new word at index 0.
REQ-024 word_cnt SHALL increment by 1 on each output transfer at index 3 and SHALL wrap modulo 2^CNT_W.
REQ-025 flush=1 in any state SHALL force the state to IDLE next cycle and discard the held word.
REQ-026 flush SHALL have priority over a same-cycle output transfer.
REQ-027 A byte transferred in the flush cycle SHALL count as delivered downstream, but word_cnt SHALL NOT increment, even at index 3.
REQ-028 flush=1 SHALL block input: in_ready = 0 that cycle, so no word is captured.
REQ-029 Latency: a word accepted at edge N SHALL present byte 0 with out_valid=1 in the cycle following edge N.
REQ-030 Throughput: with out_ready held at 1, one byte SHALL be emitted per cycle (4 cycles per word).
REQ-031 in_data SHALL be ignored when no input transfer occurs.

Reset
REQ-032 While reset=0: state = IDLE, held word = 0, index = 0, word_cnt = 0, out_valid = 0, out_last = 0, out_data = 0, out_idx = 0, and in_ready = 1 (flush low).
REQ-033 Reset assertion mid-word SHALL abort immediately (asynchronously), without completing the word.
REQ-034 Reset deassertion SHALL take effect synchronously at the next clk edge, and the first input transfer SHALL be possible on that edge.

Verification
REQ-035 MSB_FIRST=1, in_data=32'hCCC0_3003, out_ready=1 -> bytes CC,C0,30,03 on consecutive cycles, out_idx 0..3, out_last on the 4th only, word_cnt 0->1.
REQ-036 MSB_FIRST=0, same word -> bytes 03,30,C0,CC; then a back-to-back second word 32'h1122_3344 is accepted on the last-byte cycle -> 44,33,22,11 with no idle cycle between words.
REQ-037 out_ready toggled 1,0,0,1,0,1,1 during a word -> each byte held stable while stalled, all 4 bytes delivered exactly once, in order.
REQ-038 flush at out_idx=2 with in_valid=1 the same cycle -> in_ready=0, next cycle IDLE with out_valid=0, word_cnt unchanged, next word starts at index 0.
REQ-039 reset pulled low while out_idx=1 -> out_valid=0 and word_cnt=0 without waiting for a clk edge; after release, a new word emits from index 0.
REQ-040 CNT_W=2, 4 complete words -> word_cnt sequence 1,2,3,0 (wrap).

Source files
------------

// File: rtl/word_byte_sequencer.sv
// word_byte_sequencer: accepts 32-bit words and emits them as four bytes
// over a valid/ready stream, in MSB-first or LSB-first order. A new word
// can be accepted on the cycle the last byte leaves, so back-to-back words
// stream with no bubble. flush aborts the held word; word_cnt counts words
// whose last byte was delivered without a flush.
module word_byte_sequencer #(
   parameter int MSB_FIRST = 1,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [31:0]      in_data,
   output logic             in_ready,
   input  logic             flush,
   output logic             out_valid,
   output logic [7:0]       out_data,
   output logic [1:0]       out_idx,
   output logic             out_last,
   input  logic             out_ready,
   output logic [CNT_W-1:0] word_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t           state, state_nxt;
   logic [31:0]      held, held_nxt;
   logic [1:0]       idx, idx_nxt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             in_xfer;
   logic             out_xfer;
   logic [3:0][7:0]  lanes;
   logic [1:0]       lane_sel;

   // Output handshake is a pure function of the registered state, so
   // out_valid never depends on out_ready.
   assign out_valid = (state == SEND);
   assign out_idx   = idx;
   assign out_last  = out_valid && (idx == 2'd3);
   assign out_xfer  = out_valid && out_ready;

   // Accept while idle, or on the cycle the last byte leaves; flush blocks.
   assign in_ready  = !flush && ((state == IDLE) || (out_xfer && out_last));
   assign in_xfer   = in_valid && in_ready;

   // Split the held word into its four byte lanes, lane g = bits [8g+7:8g].
   genvar g;
   generate
      for (g = 0; g < 4; g++) begin : g_lane
         assign lanes[g] = held[8*g +: 8];
      end
   endgenerate

   // Emission position k maps to lane 3-k (MSB first) or lane k (LSB first).
   assign lane_sel = (MSB_FIRST != 0) ? (2'd3 - idx) : idx;
   assign out_data = out_valid ? lanes[lane_sel] : 8'h00;

   // Next-state logic: flush wins over everything, then input capture
   // (which may coincide with the last byte), then byte advance.
   always_comb begin
      state_nxt = state;
      held_nxt  = held;
      idx_nxt   = idx;
      cnt_nxt   = word_cnt;
      if (flush) begin
         state_nxt = IDLE;
         held_nxt  = 32'h0;
         idx_nxt   = 2'd0;
      end else begin
         if (out_xfer && out_last)
            cnt_nxt = word_cnt + CNT_ONE;
         if (in_xfer) begin
            state_nxt = SEND;
            held_nxt  = in_data;
            idx_nxt   = 2'd0;
         end else if (out_xfer) begin
            if (out_last) begin
               state_nxt = IDLE;
               held_nxt  = 32'h0;
               idx_nxt   = 2'd0;
            end else begin
               idx_nxt   = idx + 2'd1;
            end
         end
      end
   end

   // State, held word, byte index and completed-word counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         held     <= 32'h0;
         idx      <= 2'd0;
         word_cnt <= '0;
      end else begin
         state    <= state_nxt;
         held     <= held_nxt;
         idx      <= idx_nxt;
         word_cnt <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_word_byte_sequencer.sv
// Bench for word_byte_sequencer: two instances (MSB-first/16-bit counter and
// LSB-first/2-bit counter) share one stimulus stream. A byte-queue model
// predicts every output on every falling edge; directed sections pin the
// model with literal byte sequences and counter values.
module tb_word_byte_sequencer;

   typedef logic [7:0] bq_t[$];

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] in_data;
   logic        flush;
   logic        out_ready;

   logic        in_ready_m, out_valid_m, out_last_m;
   logic [7:0]  out_data_m;
   logic [1:0]  out_idx_m;
   logic [15:0] word_cnt_m;

   logic        in_ready_l, out_valid_l, out_last_l;
   logic [7:0]  out_data_l;
   logic [1:0]  out_idx_l;
   logic [1:0]  word_cnt_l;

   int  checks   = 0;
   int  failures = 0;
   bq_t q_m, q_l;      // bytes still to be emitted, in emission order
   bq_t acc_m, acc_l;  // bytes observed leaving each DUT
   int  m_cnt = 0;     // completed words since reset
   int  vcnt  = 0;     // cycles with out_valid seen on the MSB instance

   always #5 clk = ~clk;

   word_byte_sequencer #(.MSB_FIRST(1), .CNT_W(16)) dut_m (
      .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready_m), .flush(flush), .out_valid(out_valid_m),
      .out_data(out_data_m), .out_idx(out_idx_m), .out_last(out_last_m),
      .out_ready(out_ready), .word_cnt(word_cnt_m)
   );

   word_byte_sequencer #(.MSB_FIRST(0), .CNT_W(2)) dut_l (
      .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready_l), .flush(flush), .out_valid(out_valid_l),
      .out_data(out_data_l), .out_idx(out_idx_l), .out_last(out_last_l),
      .out_ready(out_ready), .word_cnt(word_cnt_l)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_seq(input string nm, input bq_t act, input bq_t exp);
      chk({nm, " length"}, act.size(), exp.size());
      for (int i = 0; i < exp.size() && i < act.size(); i++)
         chk($sformatf("%s byte%0d", nm, i), {24'h0, act[i]}, {24'h0, exp[i]});
   endtask

   // Advance the model by one clock edge using the inputs presented now.
   task automatic model_step();
      bit rdy;
      bit ox;
      if (!rst_n) begin
         q_m.delete(); q_l.delete(); m_cnt = 0;
         return;
      end
      rdy = !flush && (q_m.size() == 0 || (out_ready && q_m.size() == 1));
      ox  = (q_m.size() != 0) && out_ready;
      if (flush) begin
         q_m.delete(); q_l.delete();
      end else begin
         if (ox) begin
            void'(q_m.pop_front());
            void'(q_l.pop_front());
            if (q_m.size() == 0) m_cnt++;
         end
         if (in_valid && rdy) begin
            for (int k = 0; k < 4; k++) begin
               q_m.push_back(in_data[8*(3-k) +: 8]);
               q_l.push_back(in_data[8*k +: 8]);
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic reset_pulse();
      in_valid = 1'b0;
      flush    = 1'b0;
      #2;
      rst_n = 1'b0;
      q_m.delete(); q_l.delete(); m_cnt = 0;
      tick();
      #2;
      rst_n = 1'b1;
   endtask

   // Compare every output of both instances against the model each cycle.
   always @(negedge clk) begin
      int          sz;
      logic        e_v;
      logic [31:0] e_idx;
      sz    = q_m.size();
      e_v   = (sz != 0);
      e_idx = e_v ? 32'(4 - sz) : 32'd0;
      chk("in_ready_m",  {31'h0, in_ready_m},  {31'h0, !flush && (sz == 0 || (out_ready && sz == 1))});
      chk("in_ready_l",  {31'h0, in_ready_l},  {31'h0, !flush && (sz == 0 || (out_ready && sz == 1))});
      chk("out_valid_m", {31'h0, out_valid_m}, {31'h0, e_v});
      chk("out_valid_l", {31'h0, out_valid_l}, {31'h0, e_v});
      chk("out_idx_m",   {30'h0, out_idx_m},   e_idx);
      chk("out_idx_l",   {30'h0, out_idx_l},   e_idx);
      chk("out_last_m",  {31'h0, out_last_m},  {31'h0, sz == 1});
      chk("out_last_l",  {31'h0, out_last_l},  {31'h0, sz == 1});
      chk("out_data_m",  {24'h0, out_data_m},  e_v ? {24'h0, q_m[0]} : 32'h0);
      chk("out_data_l",  {24'h0, out_data_l},  e_v ? {24'h0, q_l[0]} : 32'h0);
      chk("word_cnt_m",  {16'h0, word_cnt_m},  m_cnt & 32'hFFFF);
      chk("word_cnt_l",  {30'h0, word_cnt_l},  m_cnt & 32'h3);
      if (out_valid_m && out_ready) acc_m.push_back(out_data_m);
      if (out_valid_l && out_ready) acc_l.push_back(out_data_l);
      if (out_valid_m) vcnt++;
   end

   // Directed scenarios followed by randomized traffic.
   initial begin
      int exp_wrap[4];
      exp_wrap = '{1, 2, 3, 0};
      rst_n = 1'b0; in_valid = 1'b0; in_data = 32'h0; flush = 1'b0; out_ready = 1'b0;
      tick();
      tick();
      chk("rst out_valid", {31'h0, out_valid_m}, 32'h0);
      chk("rst in_ready",  {31'h0, in_ready_m},  32'h1);
      chk("rst out_data",  {24'h0, out_data_m},  32'h0);
      chk("rst out_idx",   {30'h0, out_idx_l},   32'h0);
      chk("rst word_cnt",  {16'h0, word_cnt_m},  32'h0);
      #2 rst_n = 1'b1;

      // Single word then a back-to-back word on the last-byte cycle.
      acc_m.delete(); acc_l.delete(); vcnt = 0;
      out_ready = 1'b1; in_valid = 1'b1; in_data = 32'hCCC0_3003;
      tick();
      in_valid = 1'b0;
      chk("first byte latency", {24'h0, out_data_m}, 32'hCC);
      tick(); tick(); tick();
      chk("cnt before last", {16'h0, word_cnt_m}, 32'h0);
      in_valid = 1'b1; in_data = 32'h1122_3344;
      chk("b2b in_ready", {31'h0, in_ready_l}, 32'h1);
      tick();
      in_valid = 1'b0; in_data = 32'hFFFF_FFFF;
      chk("cnt after word1", {16'h0, word_cnt_m}, 32'h1);
      repeat (4) tick();
      chk("cnt after word2", {16'h0, word_cnt_m}, 32'h2);
      chk("no bubble", vcnt, 32'd8);
      chk_seq("msb order", acc_m, '{8'hCC, 8'hC0, 8'h30, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44});
      chk_seq("lsb order", acc_l, '{8'h03, 8'h30, 8'hC0, 8'hCC, 8'h44, 8'h33, 8'h22, 8'h11});

      // Stalls: out_ready pattern 1,0,0,1,0,1,1 after the word is taken.
      acc_m.delete(); acc_l.delete();
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA1B2_C3D4;
      tick();
      in_valid = 1'b0;
      foreach (exp_wrap[i]) ; // keep array referenced before the stall loop
      for (int i = 0; i < 7; i++) begin
         out_ready = (i == 0 || i == 3 || i == 5 || i == 6);
         tick();
      end
      chk_seq("stall msb", acc_m, '{8'hA1, 8'hB2, 8'hC3, 8'hD4});
      chk_seq("stall lsb", acc_l, '{8'hD4, 8'hC3, 8'hB2, 8'hA1});
      chk("cnt after stall", {16'h0, word_cnt_m}, 32'h3);

      // Flush at index 2 with a competing input word.
      acc_m.delete(); acc_l.delete();
      out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h5566_7788;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      flush = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
      chk("flush idx", {30'h0, out_idx_m}, 32'h2);
      chk("flush in_ready", {31'h0, in_ready_m}, 32'h0);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("post flush valid", {31'h0, out_valid_m}, 32'h0);
      chk("post flush cnt", {16'h0, word_cnt_m}, 32'h3);
      in_valid = 1'b1; in_data = 32'h0A0B_0C0D;
      tick();
      in_valid = 1'b0;
      chk("restart idx", {30'h0, out_idx_m}, 32'h0);
      chk("restart byte", {24'h0, out_data_m}, 32'h0A);
      repeat (4) tick();
      chk_seq("flush msb", acc_m, '{8'h55, 8'h66, 8'h77, 8'h0A, 8'h0B, 8'h0C, 8'h0D});
      chk("cnt after flush word", {16'h0, word_cnt_m}, 32'h4);

      // Asynchronous reset in the middle of a word.
      out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h1357_9BDF;
      tick();
      in_valid = 1'b0;
      tick();
      chk("pre reset idx", {30'h0, out_idx_m}, 32'h1);
      #2;
      rst_n = 1'b0;
      q_m.delete(); q_l.delete(); m_cnt = 0;
      #1;
      chk("async rst valid_m", {31'h0, out_valid_m}, 32'h0);
      chk("async rst valid_l", {31'h0, out_valid_l}, 32'h0);
      chk("async rst cnt_m", {16'h0, word_cnt_m}, 32'h0);
      tick();
      #2 rst_n = 1'b1;
      in_valid = 1'b1; in_data = 32'hF0E1_D2C3;
      tick();
      in_valid = 1'b0;
      chk("post rst idx", {30'h0, out_idx_m}, 32'h0);
      chk("post rst byte_m", {24'h0, out_data_m}, 32'hF0);
      chk("post rst byte_l", {24'h0, out_data_l}, 32'hC3);
      repeat (4) tick();

      // Two-bit counter wraps after four words.
      reset_pulse();
      out_ready = 1'b1;
      for (int w = 0; w < 4; w++) begin
         in_valid = 1'b1; in_data = $urandom;
         tick();
         in_valid = 1'b0;
         repeat (4) tick();
         chk($sformatf("wrap word%0d", w), {30'h0, word_cnt_l}, exp_wrap[w]);
      end

      // Random traffic including flushes that collide with inputs and last bytes.
      for (int c = 0; c < 3000; c++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         in_data   = $urandom;
         flush     = ($urandom_range(0, 19) == 0);
         out_ready = ($urandom_range(0, 9) < 6);
         tick();
      end
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      repeat (6) tick();
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
